// File: rtl/cpu_datapath_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_datapath_if : control strobes, external load values, bus and Z  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface cpu_datapath_if #(
  parameter int WIDTH = 32
);
  logic             pci, pco, iri, iro, mari, maro, mdri, mdro;
  logic             ryi, ryo, r0i, r0o, r1i, r1o;
  logic [WIDTH-1:0] pc, ir;
  logic [WIDTH-1:0] pc_immediate, ir_immediate, mar_immediate, mdr_immediate;
  logic [WIDTH-1:0] bus_q, z_hi, z_lo;

  modport master (
    output pci, pco, iri, iro, mari, maro, mdri, mdro,
    output ryi, ryo, r0i, r0o, r1i, r1o,
    output pc, ir, pc_immediate, ir_immediate, mar_immediate, mdr_immediate,
    input  bus_q, z_hi, z_lo
  );

  modport slave (
    input  pci, pco, iri, iro, mari, maro, mdri, mdro,
    input  ryi, ryo, r0i, r0o, r1i, r1o,
    input  pc, ir, pc_immediate, ir_immediate, mar_immediate, mdr_immediate,
    output bus_q, z_hi, z_lo
  );
endinterface
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_datapath : single-bus datapath, ALU op from IR[31:27], A=Y B=bus |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  wire logic     clock,
  input  wire logic     clear,
  cpu_datapath_if.slave dp
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [WIDTH-1:0]   y_q, y_d, r0_q, r0_d, r1_q, r1_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH-1:0]   bus;
  logic               driven, alu_win, alu_valid;
  logic [4:0]         op;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] alu_res, rot_r, rot_l, prod;
  logic [WIDTH-1:0]   sum, diff, sra_res;
  logic signed [WIDTH-1:0] quo, rem;
  logic               unused_reserved;

  // Reserved inputs carry no function in this revision.
  assign unused_reserved = ^{dp.pc, dp.ir};

  always_comb begin
    bus = '0;
    if      (dp.pco)  bus = pc_q;
    else if (dp.iro)  bus = ir_q;
    else if (dp.maro) bus = mar_q;
    else if (dp.mdro) bus = mdr_q;
    else if (dp.ryo)  bus = y_q;
    else if (dp.r0o)  bus = r0_q;
    else if (dp.r1o)  bus = r1_q;
  end

  assign driven  = dp.pco | dp.iro | dp.maro | dp.mdro | dp.ryo | dp.r0o | dp.r1o;
  assign alu_win = (dp.r0o | dp.r1o) & ~(dp.pco | dp.iro | dp.maro | dp.mdro | dp.ryo);

  assign op      = ir_q[WIDTH-1 -: 5];
  assign sh      = bus[SHW-1:0];
  assign sum     = y_q + bus;
  assign diff    = y_q - bus;
  assign rot_r   = {y_q, y_q} >> sh;
  assign rot_l   = {y_q, y_q} << sh;
  assign sra_res = $signed(y_q) >>> sh;
  assign prod    = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};

  always_comb begin
    quo = '0;
    rem = '0;
    if (bus != '0) begin
      quo = $signed(y_q) / $signed(bus);
      rem = $signed(y_q) % $signed(bus);
    end
  end

  always_comb begin
    alu_res   = '0;
    alu_valid = 1'b1;
    case (op)
      OP_ADD:  alu_res = {{WIDTH{sum[WIDTH-1]}}, sum};
      OP_SUB:  alu_res = {{WIDTH{diff[WIDTH-1]}}, diff};
      OP_AND:  alu_res = {{WIDTH{y_q[WIDTH-1] & bus[WIDTH-1]}}, y_q & bus};
      OP_OR:   alu_res = {{WIDTH{y_q[WIDTH-1] | bus[WIDTH-1]}}, y_q | bus};
      OP_ROR:  alu_res = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
      OP_ROL:  alu_res = {{WIDTH{1'b0}}, rot_l[2*WIDTH-1:WIDTH]};
      OP_SHR:  alu_res = {{WIDTH{1'b0}}, y_q >> sh};
      OP_SHRA: alu_res = {{WIDTH{1'b0}}, sra_res};
      OP_SHL:  alu_res = {{WIDTH{1'b0}}, y_q << sh};
      OP_MUL:  alu_res = prod;
      OP_DIV:  alu_res = {rem, quo};
      OP_NEG:  alu_res = {{WIDTH{~bus[WIDTH-1]}}, -bus} & {2*WIDTH{bus != '0}};
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~bus};
      default: alu_valid = 1'b0;
    endcase
  end

  // A register strobed while also driving the bus keeps its own value.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    r0_d  = r0_q;
    r1_d  = r1_q;
    z_d   = z_q;
    if (dp.pci  && !dp.pco)  pc_d  = driven ? bus : dp.pc_immediate;
    if (dp.iri  && !dp.iro)  ir_d  = driven ? bus : dp.ir_immediate;
    if (dp.mari && !dp.maro) mar_d = driven ? bus : dp.mar_immediate;
    if (dp.mdri && !dp.mdro) mdr_d = driven ? bus : dp.mdr_immediate;
    if (dp.ryi  && !dp.ryo)  y_d   = bus;
    if (dp.r0i  && !dp.r0o)  r0_d  = bus;
    if (dp.r1i  && !dp.r1o)  r1_d  = bus;
    if (alu_win && alu_valid) z_d  = alu_res;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      r0_q  <= '0;
      r1_q  <= '0;
      z_q   <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      r0_q  <= r0_d;
      r1_q  <= r1_d;
      z_q   <= z_d;
    end
  end

  assign dp.bus_q = bus;
  assign dp.z_hi  = z_q[2*WIDTH-1:WIDTH];
  assign dp.z_lo  = z_q[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_datapath : scoreboard bench for cpu_datapath                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cpu_datapath;

  localparam int WIDTH = 32;

  localparam logic [13:0] M_PCI  = 14'h0001, M_PCO  = 14'h0002;
  localparam logic [13:0] M_IRI  = 14'h0004, M_IRO  = 14'h0008;
  localparam logic [13:0] M_MARI = 14'h0010, M_MARO = 14'h0020;
  localparam logic [13:0] M_MDRI = 14'h0040, M_MDRO = 14'h0080;
  localparam logic [13:0] M_RYI  = 14'h0100, M_RYO  = 14'h0200;
  localparam logic [13:0] M_R0I  = 14'h0400, M_R0O  = 14'h0800;
  localparam logic [13:0] M_R1I  = 14'h1000, M_R1O  = 14'h2000;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  logic clock, clear;
  int   n_checks, n_errors;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] z_model;
  vec_t        vecs [0:13];

  cpu_datapath_if #(.WIDTH(WIDTH)) dp_if ();

  cpu_datapath #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .clear (clear),
    .dp    (dp_if.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] prev);
    logic [31:0] t;
    int          q, rm;
    int unsigned s;
    s = 32'(b[4:0]);
    t = a;
    case (op)
      5'b00011: return longint'(int'(a + b));
      5'b00100: return longint'(int'(a - b));
      5'b00101: return longint'(int'(a & b));
      5'b00110: return longint'(int'(a | b));
      5'b00111: begin
        for (int i = 0; i < int'(s); i++) t = {t[0], t[31:1]};
        return {32'h0, t};
      end
      5'b01000: begin
        for (int i = 0; i < int'(s); i++) t = {t[30:0], t[31]};
        return {32'h0, t};
      end
      5'b01001: return {32'h0, a >> s};
      5'b01010: begin
        for (int i = 0; i < int'(s); i++) t = {t[31], t[31:1]};
        return {32'h0, t};
      end
      5'b01011: return {32'h0, a << s};
      5'b01111: return longint'(int'(a)) * longint'(int'(b));
      5'b10000: begin
        if (b == 32'h0) return 64'h0;
        q  = int'(a) / int'(b);
        rm = int'(a) % int'(b);
        return {rm, q};
      end
      5'b10001: return longint'(-int'(b));
      5'b10010: return {32'h0, ~b};
      default:  return prev;
    endcase
  endfunction

  task automatic set_ctl(input logic [13:0] c);
    dp_if.pci  = c[0];  dp_if.pco  = c[1];
    dp_if.iri  = c[2];  dp_if.iro  = c[3];
    dp_if.mari = c[4];  dp_if.maro = c[5];
    dp_if.mdri = c[6];  dp_if.mdro = c[7];
    dp_if.ryi  = c[8];  dp_if.ryo  = c[9];
    dp_if.r0i  = c[10]; dp_if.r0o  = c[11];
    dp_if.r1i  = c[12]; dp_if.r1o  = c[13];
  endtask

  task automatic cycle(input logic [13:0] c);
    set_ctl(c);
    @(posedge clock);
    #1;
    set_ctl('0);
  endtask

  // Bus reads happen mid-low-phase so no strobe ever straddles a rising edge.
  task automatic peek(input string tag, input logic [13:0] drv, input logic [31:0] exp);
    @(negedge clock);
    set_ctl(drv);
    #1;
    check_value(tag, {32'h0, dp_if.bus_q}, {32'h0, exp});
    set_ctl('0);
  endtask

  task automatic mdr_to(input logic [13:0] dst, input logic [31:0] v);
    dp_if.mdr_immediate = v;
    cycle(M_MDRI);
    cycle(M_MDRO | dst);
  endtask

  task automatic alu_edge(input string tag, input logic [13:0] c, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    z_model = alu_model(op, a, b, z_model);
    exp_q.push_back(z_model);
    tag_q.push_back(tag);
    cycle(c);
    check_value(tag_q.pop_front(), {dp_if.z_hi, dp_if.z_lo}, exp_q.pop_front());
  endtask

  task automatic run_op(input vec_t v);
    mdr_to(M_IRI, {v.op, 27'h0});
    mdr_to(M_RYI, v.a);
    mdr_to(M_R0I, v.b);
    alu_edge($sformatf("op%b_%h_%h", v.op, v.a, v.b), M_R0O, v.op, v.a, v.b);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    z_model  = '0;
    vecs = '{
      '{5'b00011, 32'h7FFFFFFF, 32'h00000001},
      '{5'b00100, 32'h00000000, 32'h00000001},
      '{5'b00101, 32'hF0F0F0F0, 32'hFF00FF00},
      '{5'b00110, 32'h0F0F0000, 32'h000000F0},
      '{5'b00111, 32'h12345678, 32'h00000004},
      '{5'b01000, 32'h12345678, 32'h00000000},
      '{5'b01001, 32'h80000000, 32'h0000001F},
      '{5'b01010, 32'h80000000, 32'h00000004},
      '{5'b01011, 32'h00000001, 32'h0000001F},
      '{5'b01111, 32'h7FFFFFFF, 32'h7FFFFFFF},
      '{5'b10000, 32'hFFFFFFF9, 32'h00000002},
      '{5'b10001, 32'h00000000, 32'h00000005},
      '{5'b10010, 32'h00000000, 32'h00000000},
      '{5'b00000, 32'h00000003, 32'h00000004}
    };
    set_ctl('0);
    dp_if.pc = '0;             dp_if.ir = '0;
    dp_if.pc_immediate = '0;   dp_if.ir_immediate = '0;
    dp_if.mar_immediate = '0;  dp_if.mdr_immediate = '0;

    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_value("rst_bus",  {32'h0, dp_if.bus_q}, 64'h0);
    check_value("rst_z_hi", {32'h0, dp_if.z_hi}, 64'h0);
    check_value("rst_z_lo", {32'h0, dp_if.z_lo}, 64'h0);
    clear = 1'b0;
    peek("rst_pc",  M_PCO,  32'h0);
    peek("rst_ir",  M_IRO,  32'h0);
    peek("rst_mar", M_MARO, 32'h0);
    peek("rst_mdr", M_MDRO, 32'h0);
    peek("rst_y",   M_RYO,  32'h0);
    peek("rst_r0",  M_R0O,  32'h0);
    peek("rst_r1",  M_R1O,  32'h0);

    // Test-plan multiply: R0=-5, R1=6, IR=mul, Y<-R0, then R1 drives the ALU.
    mdr_to(M_R0I, 32'hFFFFFFFB);
    mdr_to(M_R1I, 32'h00000006);
    mdr_to(M_IRI, 32'h78000000);
    peek("ir_load", M_IRO, 32'h78000000);
    alu_edge("y_from_r0", M_R0O | M_RYI, 5'b01111, 32'h0, 32'hFFFFFFFB);
    peek("y_val", M_RYO, 32'hFFFFFFFB);
    alu_edge("mul_neg5x6", M_R1O, 5'b01111, 32'hFFFFFFFB, 32'h00000006);
    check_value("mul_const", {dp_if.z_hi, dp_if.z_lo}, 64'hFFFFFFFF_FFFFFFE2);

    mdr_to(M_IRI, 32'h80000000);
    mdr_to(M_RYI, 32'h00000007);
    mdr_to(M_R1I, 32'hFFFFFFFE);
    alu_edge("div_7_by_m2", M_R1O, 5'b10000, 32'h7, 32'hFFFFFFFE);
    check_value("div_const", {dp_if.z_hi, dp_if.z_lo}, 64'h00000001_FFFFFFFD);
    mdr_to(M_R1I, 32'h00000000);
    alu_edge("div_by_zero", M_R1O, 5'b10000, 32'h7, 32'h0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Bus priority, immediate loads, bus-over-immediate, self-reload.
    dp_if.pc_immediate = 32'h00001000;
    cycle(M_PCI);
    dp_if.mdr_immediate = 32'hCAFE0001;
    cycle(M_MDRI);
    peek("prio_pc_mdr", M_PCO | M_MDRO, 32'h00001000);
    peek("prio_mdr_y",  M_MDRO | M_RYO, 32'hCAFE0001);
    dp_if.mar_immediate = 32'h0000ABCD;
    cycle(M_MARI);
    peek("mar_imm", M_MARO, 32'h0000ABCD);
    dp_if.pc_immediate = 32'h0BADBEEF;
    cycle(M_PCI | M_MDRO);
    peek("pc_from_bus", M_PCO, 32'hCAFE0001);
    mdr_to(M_RYI, 32'h00000055);
    cycle(M_RYI | M_RYO);
    peek("y_self", M_RYO, 32'h00000055);
    cycle(M_R1I);
    peek("r1_undriven", M_R1O, 32'h0);

    // Asynchronous clear with Z nonzero, then normal operation resumes.
    run_op('{5'b10010, 32'h0, 32'h0});
    clear = 1'b1;
    #1;
    check_value("clr_async_z", {dp_if.z_hi, dp_if.z_lo}, 64'h0);
    clear = 1'b0;
    z_model = '0;
    peek("clr_y", M_RYO, 32'h0);
    run_op('{5'b00011, 32'h00000010, 32'h00000020});

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
